// File: rtl/add_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : add_seq_pkg
//  Purpose  : Shared widths and FSM state encoding for the two-operand
//             sequential adder controller.
//  Revision : 1.0 - initial release
// ============================================================================
package add_seq_pkg;

  // Operand and result widths; the result carries one extra bit for carry.
  localparam int OP_W  = 8;
  localparam int SUM_W = 9;

  // The encoding is visible on the state output port, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_B = 2'd1,
    ST_ADD    = 2'd2,
    ST_SHOW   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/add_seq_ctrl_key_edge.sv
`default_nettype none
// ============================================================================
//  Module   : key_edge
//  Purpose  : Two-flop synchronizer for a raw idle-high button level, plus a
//             one-cycle press pulse generated when the button is released
//             (synchronized level goes 0 -> 1).
//  Ports    : clk   - clock, rising edge
//             rst_n - synchronous active-low reset
//             key   - raw asynchronous button level, idle-high
//             press - one-cycle pulse on button release
//  Revision : 1.0 - initial release
// ============================================================================
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = key;
    sync2_d = sync1_q;
  end

  // Flops reset to the idle (high) level so that leaving reset with the
  // button untouched produces no spurious press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign press = sync1_q & ~sync2_q;

endmodule
`default_nettype wire

// File: rtl/add_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : add_seq_ctrl
//  Purpose  : Captures two operands from switches on successive "next" button
//             presses, adds them, and shows the 9-bit result. A "clear"
//             button returns to IDLE. led_wait blinks while an operand is
//             awaited.
//  Ports    : clk, rst_n        - clock / synchronous active-low reset
//             key_next, key_clr - raw idle-high button levels
//             sw[7:0]           - operand value
//             op_a, op_b        - latched operands
//             sum[8:0]          - op_a + op_b (bit 8 = carry)
//             sum_vld, carry    - result valid (SHOW) and qualified carry
//             state[1:0]        - IDLE=0, WAIT_B=1, ADD=2, SHOW=3
//             led_wait          - blink indicator
//  Revision : 1.0 - initial release
// ============================================================================
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int BLINK_CYC = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_next,
  input  logic             key_clr,
  input  logic [OP_W-1:0]  sw,
  output logic [OP_W-1:0]  op_a,
  output logic [OP_W-1:0]  op_b,
  output logic [SUM_W-1:0] sum,
  output logic             sum_vld,
  output logic             carry,
  output logic [1:0]       state,
  output logic             led_wait
);

  localparam int             CNT_W    = (BLINK_CYC > 2) ? $clog2(BLINK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYC - 1);

  logic next_ev;
  logic clr_ev;

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_a_q, op_a_d;
  logic [OP_W-1:0]  op_b_q, op_b_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;

  key_edge u_key_next (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_next),
    .press (next_ev)
  );

  key_edge u_key_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_clr),
    .press (clr_ev)
  );

  // FSM and datapath next-state
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;

    if (clr_ev) begin
      // Clear wins over a coincident next event and aborts a pending add.
      state_d = ST_IDLE;
      op_a_d  = '0;
      op_b_d  = '0;
      sum_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (next_ev) begin
            op_a_d  = sw;
            state_d = ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (next_ev) begin
            op_b_d  = sw;
            state_d = ST_ADD;
          end
        end
        ST_ADD: begin
          // A next event here is deliberately dropped.
          sum_d   = {1'b0, op_a_q} + {1'b0, op_b_q};
          state_d = ST_SHOW;
        end
        ST_SHOW: begin
          // Next press starts a new calculation with sw as the first operand.
          if (next_ev) begin
            op_a_d  = sw;
            op_b_d  = '0;
            sum_d   = '0;
            state_d = ST_WAIT_B;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Blink counter: restarts on every state change, free-runs only while an
  // operand is awaited.
  always_comb begin
    cnt_d = '0;
    led_d = 1'b0;
    if ((state_d == state_q) &&
        ((state_q == ST_IDLE) || (state_q == ST_WAIT_B))) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        led_d = ~led_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        led_d = led_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  // Outputs come straight from flops or are decoded from the state flop only.
  assign state    = state_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign sum      = sum_q;
  assign led_wait = led_q;
  assign sum_vld  = (state_q == ST_SHOW);
  assign carry    = sum_vld & sum_q[SUM_W-1];

endmodule
`default_nettype wire

// File: tb/tb_add_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_seq_ctrl
//  Purpose  : Self-checking bench for add_seq_ctrl (BLINK_CYC = 4). A
//             behavioural model tracks key history, operands and time spent
//             in the current state; directed table, hand sequences and random
//             stimulus are all compared against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_add_seq_ctrl;

  localparam int BLINK = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_next = 1'b1;
  logic       key_clr = 1'b1;
  logic [7:0] sw = 8'h00;
  logic [7:0] op_a, op_b;
  logic [8:0] sum;
  logic       sum_vld, carry, led_wait;
  logic [1:0] state;

  add_seq_ctrl #(.BLINK_CYC(BLINK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_next (key_next),
    .key_clr  (key_clr),
    .sw       (sw),
    .op_a     (op_a),
    .op_b     (op_b),
    .sum      (sum),
    .sum_vld  (sum_vld),
    .carry    (carry),
    .state    (state),
    .led_wait (led_wait)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: state as 0..3, operands as ints, and the number of
  // edges spent in the current waiting state (led = (stay / BLINK) odd).
  int m_state = 0, m_a = 0, m_b = 0, m_sum = 0, m_stay = 0;
  bit hn1 = 1, hn2 = 1, hc1 = 1, hc2 = 1;

  function automatic void model_update(bit r, bit kn, bit kc, logic [7:0] s);
    int  prev;
    bit  evn, evc;
    if (!r) begin
      m_state = 0; m_a = 0; m_b = 0; m_sum = 0; m_stay = 0;
      hn1 = 1; hn2 = 1; hc1 = 1; hc2 = 1;
      return;
    end
    // A key that was low two samples ago and high one sample ago fires now.
    evn  = hn1 && !hn2;
    evc  = hc1 && !hc2;
    prev = m_state;
    if (evc) begin
      m_state = 0; m_a = 0; m_b = 0; m_sum = 0;
    end else if (m_state == 2) begin
      m_sum = m_a + m_b; m_state = 3;
    end else if (evn && m_state == 0) begin
      m_a = int'(s); m_state = 1;
    end else if (evn && m_state == 1) begin
      m_b = int'(s); m_state = 2;
    end else if (evn && m_state == 3) begin
      m_a = int'(s); m_b = 0; m_sum = 0; m_state = 1;
    end
    if (m_state != prev || m_state >= 2) m_stay = 0;
    else m_stay = m_stay + 1;
    hn2 = hn1; hn1 = kn;
    hc2 = hc1; hc1 = kc;
  endfunction

  function automatic void check_model(string name);
    logic [1:0] e_st;
    logic [7:0] e_a, e_b;
    logic [8:0] e_sum;
    logic       e_vld, e_cy, e_led;
    e_st  = m_state[1:0];
    e_a   = m_a[7:0];
    e_b   = m_b[7:0];
    e_sum = m_sum[8:0];
    e_vld = (m_state == 3);
    e_cy  = e_vld && (m_sum >= 256);
    e_led = (m_state < 2) ? (((m_stay / BLINK) % 2) == 1) : 1'b0;
    vectors++;
    if ({state, op_a, op_b, sum, sum_vld, carry, led_wait} !==
        {e_st, e_a, e_b, e_sum, e_vld, e_cy, e_led}) begin
      miscompares++;
      $display("FAIL %s t=%0t got st=%0d a=%h b=%h sum=%h vld=%b cy=%b led=%b exp st=%0d a=%h b=%h sum=%h vld=%b cy=%b led=%b",
               name, $time, state, op_a, op_b, sum, sum_vld, carry, led_wait,
               e_st, e_a, e_b, e_sum, e_vld, e_cy, e_led);
    end
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %h exp %h", name, $time, act, exp);
    end
  endfunction

  task automatic step(input bit r, input bit kn, input bit kc, input logic [7:0] s,
                      input string name);
    rst_n = r; key_next = kn; key_clr = kc; sw = s;
    @(posedge clk);
    model_update(r, kn, kc, s);
    @(negedge clk);
    check_model(name);
  endtask

  // Press and release next; the action lands on the third edge.
  task automatic press(input logic [7:0] s);
    step(1, 0, 1, s, "press_lo");
    step(1, 1, 1, s, "press_hi");
    step(1, 1, 1, s, "press_act");
  endtask

  typedef struct {
    bit         r;
    bit         kn;
    bit         kc;
    logic [7:0] s;
    logic [1:0] st;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sm;
  } vec_t;

  vec_t tbl[11];

  initial begin
    bit kn_lvl;

    // Basic add: reset 3 cycles, next with 0x12, next with 0x34.
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'h00, 2'd0, 8'h00, 8'h00, 9'h000};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h00, 2'd0, 8'h00, 8'h00, 9'h000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, 2'd0, 8'h00, 8'h00, 9'h000};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h12, 2'd0, 8'h00, 8'h00, 9'h000};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'h12, 2'd0, 8'h00, 8'h00, 9'h000};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h12, 2'd1, 8'h12, 8'h00, 9'h000};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h34, 2'd1, 8'h12, 8'h00, 9'h000};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h34, 2'd1, 8'h12, 8'h00, 9'h000};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h34, 2'd2, 8'h12, 8'h34, 9'h000};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'h34, 2'd3, 8'h12, 8'h34, 9'h046};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 8'h34, 2'd3, 8'h12, 8'h34, 9'h046};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].kn, tbl[i].kc, tbl[i].s, "tbl_model");
      chk("tbl_state", 32'(state), 32'(tbl[i].st));
      chk("tbl_op_a",  32'(op_a),  32'(tbl[i].a));
      chk("tbl_op_b",  32'(op_b),  32'(tbl[i].b));
      chk("tbl_sum",   32'(sum),   32'(tbl[i].sm));
    end
    chk("basic_vld",   32'(sum_vld), 32'd1);
    chk("basic_carry", 32'(carry),   32'd0);

    // Overflow: 0xFF + 0xFF, then restart with 0x01 from SHOW.
    step(0, 1, 1, 8'h00, "ovf_rst");
    press(8'hFF);
    press(8'hFF);
    chk("ovf_add_state", 32'(state), 32'd2);
    step(1, 1, 1, 8'h00, "ovf_show");
    chk("ovf_sum",   32'(sum),   32'h1FE);
    chk("ovf_carry", 32'(carry), 32'd1);
    press(8'h01);
    chk("ovf_re_a",     32'(op_a),  32'h01);
    chk("ovf_re_sum",   32'(sum),   32'h000);
    chk("ovf_re_state", 32'(state), 32'd1);

    // Clear priority: both keys in WAIT_B.
    step(1, 0, 0, 8'hAA, "clr_lo");
    step(1, 1, 1, 8'hAA, "clr_hi");
    step(1, 1, 1, 8'hAA, "clr_act");
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_op_a",  32'(op_a),  32'd0);
    chk("clr_op_b",  32'(op_b),  32'd0);

    // Blink in IDLE: three quiet edges dark, fourth toggles on.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 8'h00, "blink_idle");
    chk("blink_idle_off", 32'(led_wait), 32'd0);
    step(1, 1, 1, 8'h00, "blink_idle");
    chk("blink_idle_on", 32'(led_wait), 32'd1);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 8'h00, "blink_idle_run");

    // Entering WAIT_B restarts the blink.
    press(8'h55);
    chk("blink_wb_enter", 32'(led_wait), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 8'h00, "blink_wb");
    chk("blink_wb_off", 32'(led_wait), 32'd0);
    step(1, 1, 1, 8'h00, "blink_wb");
    chk("blink_wb_on", 32'(led_wait), 32'd1);

    // Reset in SHOW, release with keys high.
    press(8'h20);
    step(1, 1, 1, 8'h00, "rst_show");
    chk("rst_pre_state", 32'(state), 32'd3);
    chk("rst_pre_sum",   32'(sum),   32'h075);
    step(0, 0, 0, 8'hFF, "rst_mid");
    chk("rst_mid_all", {sum, op_a, op_b, state, sum_vld, carry, led_wait}, 32'd0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 8'hFF, "rst_release");
    chk("rst_rel_state", 32'(state), 32'd0);

    // Key activity around the ADD cycle is not acted on there.
    press(8'h10);
    step(1, 0, 1, 8'h22, "drop_lo");
    step(1, 1, 1, 8'h22, "drop_hi");
    step(1, 0, 1, 8'h22, "drop_act");
    chk("drop_add", 32'(state), 32'd2);
    step(1, 0, 1, 8'h99, "drop_in_add");
    chk("drop_show_state", 32'(state), 32'd3);
    chk("drop_show_sum",   32'(sum),   32'h032);
    step(1, 0, 1, 8'h99, "drop_hold");
    chk("drop_hold_state", 32'(state), 32'd3);
    step(1, 1, 1, 8'h99, "drop_rel1");
    step(1, 1, 1, 8'h99, "drop_rel2");

    // Randomized traffic against the model.
    kn_lvl = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit r, kc;
      if ($urandom_range(0, 99) < 30) kn_lvl = ~kn_lvl;
      r  = ($urandom_range(0, 99) >= 2);
      kc = ($urandom_range(0, 99) >= 4);
      step(r, kn_lvl, kc, 8'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising edge only) and rst_n input 1 (sampled on clk; 0 = reset).
REQ-002 Parameter BLINK_CYC SHALL default to 25_000_000 and set the clk cycles per led_wait half-period; legal range is 2 or more.
REQ-003 key_next input 1 SHALL be the raw operand-capture button level, idle-high.
REQ-004 key_clr input 1 SHALL be the raw clear button level, idle-high.
REQ-005 sw input 8 SHALL carry the operand value from the switches.
REQ-006 op_a output 8 SHALL be the latched first operand.
REQ-007 op_b output 8 SHALL be the latched second operand.
REQ-008 sum output 9 SHALL be op_a + op_b, with bit 8 as carry.
REQ-009 sum_vld output 1 SHALL be high only while state is SHOW.
REQ-010 carry output 1 SHALL equal sum[8] while sum_vld is high, and 0 otherwise.
REQ-011 state output 2 SHALL encode IDLE=0, WAIT_B=1, ADD=2, SHOW=3.
REQ-012 led_wait output 1 SHALL blink while an operand is awaited.

Function
REQ-013 Each key SHALL pass through a 2-flop synchronizer.
REQ-014 A press event SHALL be a one-cycle pulse when the first sync flop is 1 and the second is 0, i.e. on button release.
REQ-015 An FSM action SHALL occur at the 2nd clk rising edge after the key input rises.
REQ-016 IDLE: on a next event, op_a SHALL take sw and the FSM SHALL go to WAIT_B; otherwise the FSM SHALL hold.
REQ-017 WAIT_B: on a next event, op_b SHALL take sw and the FSM SHALL go to ADD.
REQ-018 ADD SHALL last exactly one cycle: sum takes {1'b0,op_a}+{1'b0,op_b}, then the FSM goes to SHOW.
REQ-019 SHOW: sum, op_a and op_b SHALL hold.
REQ-020 SHOW: on a next event, op_a SHALL take sw, op_b and sum SHALL clear to 0, and the FSM SHALL go to WAIT_B.
REQ-021 A next event during ADD SHALL be ignored (dropped, not queued).
REQ-022 A clr event in any state SHALL force IDLE and clear op_a, op_b and sum to 0 at that edge.
REQ-023 On a simultaneous clr and next event, clr SHALL win and sw SHALL NOT be captured.
REQ-024 A clr event during ADD SHALL abort the add, leaving sum 0.
REQ-025 Blink counter: it SHALL count 0..BLINK_CYC-1 in IDLE and WAIT_B; on wrap from BLINK_CYC-1 to 0, led_wait SHALL toggle.
REQ-026 On any state change, the counter SHALL restart at 0 and led_wait SHALL be 0.
REQ-027 In ADD and SHOW, the counter SHALL hold 0 and led_wait SHALL be 0.
REQ-028 Arithmetic SHALL be unsigned 8+8 into 9 bits with no saturation (255+255 = 510, carry = 1).
REQ-029 All outputs SHALL be registered or decoded only from registered state, with no combinational path from sw or the keys to the outputs.

Reset
REQ-030 While rst_n=0 at a clk edge, the following SHALL be 0: state (IDLE), op_a, op_b, sum, sum_vld, carry, led_wait and the blink counter.
REQ-031 While rst_n=0, synchronizer flops SHALL load 1 (idle level), so that releasing reset with keys idle yields no event.
REQ-032 Reset asserted mid-operation, in any state, SHALL behave identically to REQ-030 and REQ-031 and SHALL override clr and next.
REQ-033 Reset release SHALL need no settling cycles: an event arriving at the first edge after release SHALL be honoured.

Structure
REQ-034 Package add_seq_pkg SHALL hold the state encoding constants, OP_W=8 and SUM_W=9.
REQ-035 Sub-module key_edge (clk, rst_n, key, press) SHALL implement REQ-013 and REQ-014, with two instances (next, clr).
REQ-036 The FSM, operand registers, adder and blink counter SHALL sit in add_seq_ctrl.
REQ-037 Seven-segment decoding SHALL stay outside this block.

Verification (bench BLINK_CYC=4)
REQ-038 Basic add: rst_n low 3 cycles then high; sw=0x12 with next pulse; sw=0x34 with next pulse -> sum=0x046, carry=0, sum_vld=1, state=3, one cycle after state=2.
REQ-039 Overflow: operands 0xFF and 0xFF -> sum=0x1FE, carry=1; then next with sw=0x01 -> op_a=0x01, sum=0, state=1.
REQ-040 Clear priority: in WAIT_B, key_next and key_clr rise on the same cycle -> state=0, op_a=op_b=sum=0, sw not captured.
REQ-041 Blink: in IDLE with no keys -> led_wait toggles every 4 cycles; entering WAIT_B -> led_wait=0, counter restarts, first toggle 4 cycles later.
REQ-042 Reset and glitch: assert rst_n low in SHOW -> all outputs 0 at that edge; release with keys held high -> no event, state stays 0.
REQ-043 Drop in ADD: next event timed at the ADD cycle -> ignored, state goes to SHOW with the correct sum.
